// File: rtl/otter_branch_predictor.sv
`default_nettype none
//==============================================================================
// Module   : otter_branch_predictor
// Purpose  : Direct-mapped branch target buffer with per-entry saturating
//            direction counters for the pipelined OTTER RV32I core.
//            Fetch side performs a zero-latency lookup on if_pc and supplies
//            the predicted next PC. Execute side compares the resolved
//            outcome against the prediction carried down the pipe, flags a
//            redirect, and trains the tables on the next clock edge.
// Ports    : clk, RST (sync, active-high)
//            if_pc / if_pred_taken / if_pred_target       - fetch lookup
//            ex_valid, ex_stall, ex_kind, ex_pc, ex_taken,
//            ex_target, ex_pred_taken, ex_pred_target     - resolved branch
//            ex_mispredict / ex_redirect_pc               - redirect request
//            stat_branches / stat_mispredicts             - optional counters
// Options  : define OTTER_BP_STATS_EN to add the saturating statistics
//            counters stat_branches and stat_mispredicts.
// Revision : 1.0 - initial release
//==============================================================================
module otter_branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic [1:0]  ex_kind,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] ex_redirect_pc
`ifdef OTTER_BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_BR   = 2'b01;
    localparam logic [1:0] c_KIND_JAL  = 2'b10;
    localparam logic [1:0] c_KIND_JALR = 2'b11;

    localparam logic [CTR_W-1:0] c_CTR_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] c_CTR_MAX = '1;
    localparam logic [CTR_W-1:0] c_CTR_MIN = '0;
    // Weakly taken is the MSB alone; weakly not-taken sits just below it.
    localparam logic [CTR_W-1:0] c_CTR_WT  = c_CTR_ONE << (CTR_W - 1);
    localparam logic [CTR_W-1:0] c_CTR_WNT = c_CTR_WT - c_CTR_ONE;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic              r_jal    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [CTR_W-1:0]  r_ctr    [ENTRIES];

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic              w_upd;
    logic              w_unused;

    // PC bits outside the index/tag window do not take part in the lookup.
    assign w_unused = ^{if_pc, ex_pc};

    //--------------------------------------------------------------------------
    // Fetch-side lookup (reads pre-update contents on a same-index update)
    //--------------------------------------------------------------------------
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign if_pred_taken  = w_if_hit && (r_jal[w_if_idx] || r_ctr[w_if_idx][CTR_W-1]);
    assign if_pred_target = if_pred_taken ? r_target[w_if_idx] : (if_pc + 32'd4);

    //--------------------------------------------------------------------------
    // Execute-side resolution
    //--------------------------------------------------------------------------
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd    = ex_valid && !ex_stall;

    assign ex_mispredict  = w_upd && ((ex_pred_taken != ex_taken) ||
                                      (ex_taken && (ex_pred_target != ex_target)));
    assign ex_redirect_pc = !w_upd  ? 32'd0 :
                            ex_taken ? ex_target : (ex_pc + 32'd4);

    //--------------------------------------------------------------------------
    // Table training
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_jal[i]    <= 1'b0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= c_CTR_WNT;
            end
        end else if (w_upd) begin
            case (ex_kind)
                c_KIND_BR: begin
                    if (w_ex_hit) begin
                        if (ex_taken) begin
                            r_target[w_ex_idx] <= ex_target;
                            if (r_ctr[w_ex_idx] != c_CTR_MAX)
                                r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + c_CTR_ONE;
                        end else if (r_ctr[w_ex_idx] != c_CTR_MIN) begin
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - c_CTR_ONE;
                        end
                    end else if (ex_taken) begin
                        r_valid[w_ex_idx]  <= 1'b1;
                        r_tag[w_ex_idx]    <= w_ex_tag;
                        r_jal[w_ex_idx]    <= 1'b0;
                        r_target[w_ex_idx] <= ex_target;
                        r_ctr[w_ex_idx]    <= c_CTR_WT;
                    end
                end
                c_KIND_JAL: begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_jal[w_ex_idx]    <= 1'b1;
                    r_target[w_ex_idx] <= ex_target;
                    r_ctr[w_ex_idx]    <= c_CTR_MAX;
                end
                c_KIND_NONE: begin
                    // A hit on a non-branch is an alias from another PC;
                    // drop the entry so it stops steering fetch.
                    if (w_ex_hit && ex_mispredict)
                        r_valid[w_ex_idx] <= 1'b0;
                end
                c_KIND_JALR: begin
                    // Register-indirect targets are not cached.
                end
                default: begin
                end
            endcase
        end
    end

`ifdef OTTER_BP_STATS_EN
    //--------------------------------------------------------------------------
    // Saturating statistics counters
    //--------------------------------------------------------------------------
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_stat_br <= 32'd0;
            r_stat_mp <= 32'd0;
        end else begin
            if (w_upd && (ex_kind != c_KIND_NONE) && (r_stat_br != 32'hFFFF_FFFF))
                r_stat_br <= r_stat_br + 32'd1;
            if (ex_mispredict && (r_stat_mp != 32'hFFFF_FFFF))
                r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_otter_branch_predictor.sv
`default_nettype none
//==============================================================================
// Module   : tb_otter_branch_predictor
// Purpose  : Scoreboard bench for otter_branch_predictor. A driver issues one
//            request per cycle, predicts the response from a table-level
//            model of the predictor and queues it; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
//==============================================================================
module tb_otter_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CTR_TOP = (1 << CTR_W) - 1;
    localparam int CTR_MID = 1 << (CTR_W - 1);

    logic        clk;
    logic        RST;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_stall;
    logic [1:0]  ex_kind;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
`ifdef OTTER_BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    otter_branch_predictor #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CTR_W   (CTR_W)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_kind        (ex_kind),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_mispredict  (ex_mispredict),
        .ex_redirect_pc (ex_redirect_pc)
`ifdef OTTER_BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        int unsigned tag;
        bit          jal;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    typedef struct {
        logic [31:0] ipc;
        bit          pt;
        logic [31:0] ptg;
        bit          mp;
        logic [31:0] rd;
        longint      sb;
        longint      sm;
    } exp_t;

    ent_t   tab [ENTRIES];
    exp_t   q [$];
    longint m_sb;
    longint m_sm;
    int     checks;
    int     failures;

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    function automatic bit f_hit(input logic [31:0] pc);
        return tab[f_idx(pc)].v && (tab[f_idx(pc)].tag == f_tag(pc));
    endfunction

    function automatic bit f_pt(input logic [31:0] pc);
        return f_hit(pc) && (tab[f_idx(pc)].jal || (tab[f_idx(pc)].ctr >= CTR_MID));
    endfunction

    function automatic logic [31:0] f_ptg(input logic [31:0] pc);
        return f_pt(pc) ? tab[f_idx(pc)].tgt : pc + 32'd4;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            tab[i].v   = 1'b0;
            tab[i].tag = 0;
            tab[i].jal = 1'b0;
            tab[i].tgt = 32'd0;
            tab[i].ctr = CTR_MID - 1;
        end
        m_sb = 0;
        m_sm = 0;
    endfunction

    function automatic void m_alloc(input logic [31:0] pc, input logic [31:0] tgt,
                                    input bit jal, input int ctr);
        tab[f_idx(pc)].v   = 1'b1;
        tab[f_idx(pc)].tag = f_tag(pc);
        tab[f_idx(pc)].jal = jal;
        tab[f_idx(pc)].tgt = tgt;
        tab[f_idx(pc)].ctr = ctr;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input bit r, input logic [31:0] ipc, input bit v, input bit st,
                       input logic [1:0] k, input logic [31:0] epc, input bit tk,
                       input logic [31:0] tgt, input bit pt, input logic [31:0] ptt);
        exp_t        e;
        bit          upd;
        bit          hit;
        int unsigned ix;
        @(posedge clk);
        #1;
        RST = r; if_pc = ipc; ex_valid = v; ex_stall = st; ex_kind = k;
        ex_pc = epc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ptt;

        upd   = v && !st;
        e.ipc = ipc;
        e.pt  = f_pt(ipc);
        e.ptg = f_ptg(ipc);
        e.mp  = upd && ((pt != tk) || (tk && (ptt != tgt)));
        e.rd  = !upd ? 32'd0 : (tk ? tgt : epc + 32'd4);
        e.sb  = m_sb;
        e.sm  = m_sm;
        q.push_back(e);

        if (r) begin
            m_reset();
        end else begin
            if (upd && k != 2'd0 && m_sb < 64'hFFFF_FFFF) m_sb++;
            if (e.mp && m_sm < 64'hFFFF_FFFF) m_sm++;
            hit = f_hit(epc);
            ix  = f_idx(epc);
            if (upd) begin
                case (k)
                    2'd1: begin
                        if (hit) begin
                            if (tk) begin
                                tab[ix].tgt = tgt;
                                if (tab[ix].ctr < CTR_TOP) tab[ix].ctr++;
                            end else if (tab[ix].ctr > 0) begin
                                tab[ix].ctr--;
                            end
                        end else if (tk) begin
                            m_alloc(epc, tgt, 1'b0, CTR_MID);
                        end
                    end
                    2'd2:    m_alloc(epc, tgt, 1'b1, CTR_TOP);
                    2'd0:    if (hit && e.mp) tab[ix].v = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        cyc(1'b0, ipc, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    function automatic logic [31:0] mkpc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 2)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_0000);
        return pc;
    endfunction

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req,
                       input logic [31:0] pc);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s if_pc=%h actual=%h required=%h time=%0t", name, pc, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("if_pred_taken",  32'(if_pred_taken), 32'(e.pt),  e.ipc);
                chk("if_pred_target", if_pred_target,     e.ptg,      e.ipc);
                chk("ex_mispredict",  32'(ex_mispredict), 32'(e.mp),  e.ipc);
                chk("ex_redirect_pc", ex_redirect_pc,     e.rd,       e.ipc);
`ifdef OTTER_BP_STATS_EN
                chk("stat_branches",    stat_branches,    32'(e.sb), e.ipc);
                chk("stat_mispredicts", stat_mispredicts, 32'(e.sm), e.ipc);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ipc, epc, tgt, ptt;
        logic [1:0]  k;
        bit          tk, pt;
        checks = 0; failures = 0;
        m_reset();
        RST = 1'b1; if_pc = 32'd0; ex_valid = 1'b0; ex_stall = 1'b0; ex_kind = 2'd0;
        ex_pc = 32'd0; ex_taken = 1'b0; ex_target = 32'd0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        repeat (3) @(posedge clk);

        // Directed: post-reset lookup, allocation, counter walk, JAL + stall, aliasing
        idle(32'h100);
        cyc(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        idle(32'h100);
        cyc(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        cyc(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        cyc(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        cyc(1'b0, 32'h100, 1'b1, 1'b0, 2'd1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        idle(32'h100);
        cyc(1'b0, 32'h200, 1'b1, 1'b0, 2'd2, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        cyc(1'b0, 32'h200, 1'b1, 1'b1, 2'd2, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        idle(32'h200);
        idle(32'h100);
        cyc(1'b0, 32'h300, 1'b1, 1'b0, 2'd0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
        idle(32'h200);
        idle(32'hFFFF_FFFC);
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 2'd2, 32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
        idle(32'h100);

        // Randomised traffic over a small aliasing address pool
        for (int n = 0; n < 3000; n++) begin
            ipc = mkpc();
            epc = mkpc();
            k   = 2'($urandom_range(0, 3));
            tk  = (k >= 2'd2) ? 1'b1 : ((k == 2'd1) ? 1'($urandom_range(0, 1)) : 1'b0);
            tgt = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : mkpc();
            if ($urandom_range(0, 9) < 7) begin
                pt = f_pt(epc); ptt = f_ptg(epc);
            end else begin
                pt = 1'($urandom_range(0, 1)); ptt = pt ? tgt : epc + 32'd4;
            end
            cyc(($urandom_range(0, 199) == 0), ipc, ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 4) == 0), k, epc, tk, tgt, pt, ptt);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
